request_arbiter: RTL and testbench

- Round-robin arbiter that merges NUM_REQUEST independent requestor ports into a single request stream.
- Sits directly upstream of the team's FIFO queue and drives its request_in / request_valid_in / issue_ack_out handshake.
- Holds one granted request until the downstream ack arrives, then returns a one-cycle ack pulse to the winning requestor only.
- Fairness: the priority pointer rotates past each winner.

---
 rtl/request_arbiter.sv | 84 ++++++++
 tb/tb_request_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_arbiter.sv
// Round-robin arbiter that merges NUM_REQUEST requestor ports into one request stream.
// A grant is held until the downstream ack, then a one-cycle ack pulse goes back to the winner.
module request_arbiter #(
  parameter int NUM_REQUEST                = 4,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_REQUEST_LOG2           = $clog2(NUM_REQUEST)
) (
  input  logic                                              clk_in,
  input  logic                                              reset_in,
  input  logic [NUM_REQUEST*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
  input  logic [NUM_REQUEST-1:0]                            request_valid_packed_in,
  output logic [NUM_REQUEST-1:0]                            issue_ack_packed_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]             request_out,
  output logic                                              request_valid_out,
  input  logic                                              issue_ack_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t                                state;
  logic [NUM_REQUEST_LOG2-1:0]           last_grant;
  logic [NUM_REQUEST_LOG2-1:0]           grant_idx;
  logic [NUM_REQUEST_LOG2-1:0]           winner;
  logic [NUM_REQUEST_LOG2-1:0]           candidate;
  logic                                  found;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] payload [NUM_REQUEST];

  for (genvar i = 0; i < NUM_REQUEST; i++) begin : g_unpack
    assign payload[i] = request_packed_in[i*SINGLE_ENTRY_WIDTH_IN_BITS +: SINGLE_ENTRY_WIDTH_IN_BITS];
  end

  // First valid port found by scanning cyclically from the port after the last winner.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    candidate = '0;
    for (int k = 1; k <= NUM_REQUEST; k++) begin
      candidate = NUM_REQUEST_LOG2'((int'(last_grant) + k) % NUM_REQUEST);
      if (!found && request_valid_packed_in[candidate]) begin
        found  = 1'b1;
        winner = candidate;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state                <= IDLE;
      last_grant           <= NUM_REQUEST_LOG2'(NUM_REQUEST - 1);
      grant_idx            <= '0;
      request_out          <= '0;
      request_valid_out    <= 1'b0;
      issue_ack_packed_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          issue_ack_packed_out <= '0;
          if (found) begin
            request_out       <= payload[winner];
            request_valid_out <= 1'b1;
            grant_idx         <= winner;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_ack_in) begin
            request_out          <= '0;
            request_valid_out    <= 1'b0;
            issue_ack_packed_out <= NUM_REQUEST'(1) << grant_idx;
            last_grant           <= grant_idx;
            state                <= ACK;
          end
        end
        // The acked requestor still shows valid here, so no grant is attempted.
        ACK: begin
          issue_ack_packed_out <= '0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_request_arbiter.sv
// Self-checking bench for request_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_request_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk_in = 1'b0;
  logic           reset_in;
  logic [N*W-1:0] request_packed_in;
  logic [N-1:0]   request_valid_packed_in;
  logic [N-1:0]   issue_ack_packed_out;
  logic [W-1:0]   request_out;
  logic           request_valid_out;
  logic           issue_ack_in;

  int checks = 0;
  int fails  = 0;

  request_arbiter #(
    .NUM_REQUEST(N),
    .SINGLE_ENTRY_WIDTH_IN_BITS(W)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .request_packed_in(request_packed_in),
    .request_valid_packed_in(request_valid_packed_in),
    .issue_ack_packed_out(issue_ack_packed_out),
    .request_out(request_out),
    .request_valid_out(request_valid_out),
    .issue_ack_in(issue_ack_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_payload(input int p, input logic [W-1:0] v);
    request_packed_in[p*W +: W] = v;
  endtask

  function automatic logic [W-1:0] rand_payload();
    return {$urandom, $urandom};
  endfunction

  // Round-robin rule: first valid port after the previous winner, wrapping around.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset_in = 1'b1;
    issue_ack_in = 1'b0;
    request_valid_packed_in = '0;
    request_packed_in = '0;
    tick();
    tick();
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    issue_ack_in = 1'b1;
    request_valid_packed_in = '1;
    for (int p = 0; p < N; p++) set_payload(p, rand_payload());
    tick();
    tick();
    checks++;
    if (request_valid_out !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_valid: got %b expected 0", request_valid_out);
    end
    checks++;
    if (request_out !== '0) begin
      fails++; $display("[TB] FAIL reset_out: got %h expected 0", request_out);
    end
    checks++;
    if (issue_ack_packed_out !== '0) begin
      fails++; $display("[TB] FAIL reset_ack: got %b expected 0", issue_ack_packed_out);
    end
    reset_in = 1'b0;
    issue_ack_in = 1'b0;
    request_valid_packed_in = '0;
    tick();
    checks++;
    if ({request_valid_out, issue_ack_packed_out} !== '0) begin
      fails++; $display("[TB] FAIL reset_idle: got %b expected 0", {request_valid_out, issue_ack_packed_out});
    end
  endtask

  task automatic test_single_request();
    do_reset();
    set_payload(2, 64'hA5);
    request_valid_packed_in = 4'b0100;
    tick();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({request_valid_out, request_out, issue_ack_packed_out} !== {1'b1, 64'hA5, 4'b0000}) begin
        fails++; $display("[TB] FAIL single_grant c%0d: got %b/%h/%b expected 1/a5/0000", c, request_valid_out, request_out, issue_ack_packed_out);
      end
      if (c == 0) tick();
    end
    issue_ack_in = 1'b1;
    tick();
    issue_ack_in = 1'b0;
    checks++;
    if ({request_valid_out, issue_ack_packed_out} !== {1'b0, 4'b0100}) begin
      fails++; $display("[TB] FAIL single_ack: got %b/%b expected 0/0100", request_valid_out, issue_ack_packed_out);
    end
    tick();
    request_valid_packed_in = '0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({request_valid_out, issue_ack_packed_out} !== '0) begin
        fails++; $display("[TB] FAIL single_quiet c%0d: got %b/%b expected 0/0000", c, request_valid_out, issue_ack_packed_out);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ack;
    do_reset();
    for (int p = 0; p < N; p++) set_payload(p, 64'(16 + p));
    request_valid_packed_in = '1;
    tick();
    for (int g = 0; g < 5; g++) begin
      checks++;
      if ({request_valid_out, request_out} !== {1'b1, 64'(16 + g % N)}) begin
        fails++; $display("[TB] FAIL rr_grant g%0d: got %b/%h expected 1/%h", g, request_valid_out, request_out, 64'(16 + g % N));
      end
      tick();
      issue_ack_in = 1'b1;
      tick();
      issue_ack_in = 1'b0;
      exp_ack = '0;
      exp_ack[g % N] = 1'b1;
      checks++;
      if (issue_ack_packed_out !== exp_ack) begin
        fails++; $display("[TB] FAIL rr_ack g%0d: got %b expected %b", g, issue_ack_packed_out, exp_ack);
      end
      tick();
      checks++;
      if ({request_valid_out, issue_ack_packed_out} !== '0) begin
        fails++; $display("[TB] FAIL rr_gap g%0d: got %b/%b expected 0/0000", g, request_valid_out, issue_ack_packed_out);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] pl;
    do_reset();
    pl = rand_payload();
    set_payload(1, pl);
    request_valid_packed_in = 4'b0010;
    tick();
    for (int c = 0; c < 21; c++) begin
      checks++;
      if ({request_valid_out, request_out, issue_ack_packed_out} !== {1'b1, pl, 4'b0000}) begin
        fails++; $display("[TB] FAIL stall_hold c%0d: got %b/%h/%b expected 1/%h/0000", c, request_valid_out, request_out, issue_ack_packed_out, pl);
      end
      if (c < 20) tick();
    end
    issue_ack_in = 1'b1;
    tick();
    issue_ack_in = 1'b0;
    checks++;
    if ({request_valid_out, issue_ack_packed_out} !== {1'b0, 4'b0010}) begin
      fails++; $display("[TB] FAIL stall_ack: got %b/%b expected 0/0010", request_valid_out, issue_ack_packed_out);
    end
    tick();
    request_valid_packed_in = '0;
    tick();
  endtask

  task automatic test_stray_ack();
    logic [W-1:0] pl0, pl1;
    do_reset();
    issue_ack_in = 1'b1;
    tick();
    issue_ack_in = 1'b0;
    tick();
    checks++;
    if ({request_valid_out, request_out, issue_ack_packed_out} !== '0) begin
      fails++; $display("[TB] FAIL stray_idle: got %b/%h/%b expected all 0", request_valid_out, request_out, issue_ack_packed_out);
    end
    pl0 = rand_payload();
    pl1 = rand_payload();
    set_payload(0, pl0);
    set_payload(1, pl1);
    request_valid_packed_in = 4'b0001;
    tick();
    checks++;
    if ({request_valid_out, request_out} !== {1'b1, pl0}) begin
      fails++; $display("[TB] FAIL stray_grant0: got %b/%h expected 1/%h", request_valid_out, request_out, pl0);
    end
    issue_ack_in = 1'b1;
    tick();
    checks++;
    if (issue_ack_packed_out !== 4'b0001) begin
      fails++; $display("[TB] FAIL stray_ack0: got %b expected 0001", issue_ack_packed_out);
    end
    tick();
    issue_ack_in = 1'b0;
    checks++;
    if ({request_valid_out, request_out, issue_ack_packed_out} !== '0) begin
      fails++; $display("[TB] FAIL stray_in_ack: got %b/%h/%b expected all 0", request_valid_out, request_out, issue_ack_packed_out);
    end
    request_valid_packed_in = 4'b0010;
    tick();
    checks++;
    if ({request_valid_out, request_out, issue_ack_packed_out} !== {1'b1, pl1, 4'b0000}) begin
      fails++; $display("[TB] FAIL stray_next_grant: got %b/%h/%b expected 1/%h/0000", request_valid_out, request_out, issue_ack_packed_out, pl1);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_issue();
    logic [W-1:0] pl0, pl3;
    do_reset();
    pl0 = rand_payload();
    pl3 = rand_payload();
    set_payload(0, pl0);
    set_payload(3, pl3);
    request_valid_packed_in = 4'b1000;
    tick();
    checks++;
    if ({request_valid_out, request_out} !== {1'b1, pl3}) begin
      fails++; $display("[TB] FAIL midrst_grant3: got %b/%h expected 1/%h", request_valid_out, request_out, pl3);
    end
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    checks++;
    if ({request_valid_out, request_out, issue_ack_packed_out} !== '0) begin
      fails++; $display("[TB] FAIL midrst_clear: got %b/%h/%b expected all 0", request_valid_out, request_out, issue_ack_packed_out);
    end
    request_valid_packed_in = 4'b1001;
    tick();
    checks++;
    if ({request_valid_out, request_out} !== {1'b1, pl0}) begin
      fails++; $display("[TB] FAIL midrst_port0_wins: got %b/%h expected 1/%h", request_valid_out, request_out, pl0);
    end
    issue_ack_in = 1'b1;
    tick();
    issue_ack_in = 1'b0;
    checks++;
    if (issue_ack_packed_out !== 4'b0001) begin
      fails++; $display("[TB] FAIL midrst_ack0: got %b expected 0001", issue_ack_packed_out);
    end
    do_reset();
  endtask

  task automatic test_wrap();
    logic [W-1:0] pl0, pl2, pl3;
    do_reset();
    pl0 = rand_payload();
    pl2 = rand_payload();
    pl3 = rand_payload();
    set_payload(0, pl0);
    set_payload(2, pl2);
    set_payload(3, pl3);
    request_valid_packed_in = 4'b1000;
    tick();
    checks++;
    if ({request_valid_out, request_out} !== {1'b1, pl3}) begin
      fails++; $display("[TB] FAIL wrap_grant3: got %b/%h expected 1/%h", request_valid_out, request_out, pl3);
    end
    issue_ack_in = 1'b1;
    tick();
    issue_ack_in = 1'b0;
    checks++;
    if (issue_ack_packed_out !== 4'b1000) begin
      fails++; $display("[TB] FAIL wrap_ack3: got %b expected 1000", issue_ack_packed_out);
    end
    tick();
    request_valid_packed_in = 4'b0101;
    tick();
    checks++;
    if ({request_valid_out, request_out} !== {1'b1, pl0}) begin
      fails++; $display("[TB] FAIL wrap_grant0: got %b/%h expected 1/%h", request_valid_out, request_out, pl0);
    end
    issue_ack_in = 1'b1;
    tick();
    issue_ack_in = 1'b0;
    checks++;
    if (issue_ack_packed_out !== 4'b0001) begin
      fails++; $display("[TB] FAIL wrap_ack0: got %b expected 0001", issue_ack_packed_out);
    end
    tick();
    request_valid_packed_in = 4'b0100;
    tick();
    checks++;
    if ({request_valid_out, request_out} !== {1'b1, pl2}) begin
      fails++; $display("[TB] FAIL wrap_grant2: got %b/%h expected 1/%h", request_valid_out, request_out, pl2);
    end
    issue_ack_in = 1'b1;
    tick();
    issue_ack_in = 1'b0;
    checks++;
    if (issue_ack_packed_out !== 4'b0100) begin
      fails++; $display("[TB] FAIL wrap_ack2: got %b expected 0100", issue_ack_packed_out);
    end
    tick();
    request_valid_packed_in = '0;
    tick();
  endtask

  // Transaction view: idle -> grant -> waiting for downstream ack -> ack pulse -> idle.
  task automatic test_random();
    logic [N-1:0]   a_vld, exp_ack;
    logic [N*W-1:0] a_pay;
    logic           a_ack, a_rst, exp_v;
    logic [W-1:0]   exp_out, held;
    int phase, m_last, w, drop_port, drop_cd;
    do_reset();
    phase = 0; m_last = N - 1; w = 0; drop_port = 0; drop_cd = 0; held = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      a_vld = request_valid_packed_in;
      a_pay = request_packed_in;
      a_ack = issue_ack_in;
      a_rst = reset_in;
      tick();
      exp_v = 1'b0; exp_out = '0; exp_ack = '0;
      if (a_rst) begin
        phase = 0;
        m_last = N - 1;
      end else if (phase == 0) begin
        if (a_vld != '0) begin
          w = rr_pick(a_vld, m_last);
          held = a_pay[w*W +: W];
          exp_v = 1'b1;
          exp_out = held;
          phase = 1;
        end
      end else if (phase == 1) begin
        if (a_ack) begin
          exp_ack[w] = 1'b1;
          m_last = w;
          drop_port = w;
          drop_cd = 2;
          phase = 2;
        end else begin
          exp_v = 1'b1;
          exp_out = held;
        end
      end else begin
        phase = 0;
      end
      checks++;
      if ({request_valid_out, request_out, issue_ack_packed_out} !== {exp_v, exp_out, exp_ack}) begin
        fails++; $display("[TB] FAIL random cyc%0d: got %b/%h/%b expected %b/%h/%b", cyc, request_valid_out, request_out, issue_ack_packed_out, exp_v, exp_out, exp_ack);
      end
      reset_in = ($urandom_range(0, 79) == 0);
      issue_ack_in = ($urandom_range(0, 2) == 0);
      if (drop_cd == 1) request_valid_packed_in[drop_port] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!(drop_cd == 1 && i == drop_port)) begin
          if (!request_valid_packed_in[i] && $urandom_range(0, 3) == 0) begin
            set_payload(i, rand_payload());
            request_valid_packed_in[i] = 1'b1;
          end else if (request_valid_packed_in[i] && $urandom_range(0, 7) == 0) begin
            set_payload(i, rand_payload());
          end
        end
      end
      if (drop_cd > 0) drop_cd--;
    end
    reset_in = 1'b0;
    issue_ack_in = 1'b0;
    request_valid_packed_in = '0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_in = 1'b1;
    issue_ack_in = 1'b0;
    request_valid_packed_in = '0;
    request_packed_in = '0;
    test_reset();
    test_single_request();
    test_round_robin();
    test_stall();
    test_stray_ack();
    test_reset_mid_issue();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
